// File: rtl/reg_file_sb_pkg.sv
// Shared sizing constants and helpers for the register file / scoreboard slice.
package reg_file_sb_pkg;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int ZERO_REG_IDX   = 0;

  // A single-register file still needs a one-bit address bus.
  function automatic int reg_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REG_ADDR_W = reg_addr_w(DEF_NUM_REGS);
endpackage

// File: rtl/reg_file_sb_demux.sv
// Select-driven demux: routes i_data to output i_sel, all outputs zero when i_sel is out of range.
module reg_file_sb_demux #(
  parameter int DATA_WIDTH  = 1,
  parameter int NUM_OUTPUTS = 4,
  parameter int SEL_W       = 2
) (
  input  logic [DATA_WIDTH-1:0]                  i_data,
  input  logic [SEL_W-1:0]                       i_sel,
  output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] o_data
);
  always_comb begin
    o_data = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++)
      if ({1'b0, i_sel} == (SEL_W+1)'(i)) o_data[i] = i_data;
  end
endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with two bypassed combinational read ports and a busy scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ZERO_REG   = 1,
  localparam int AW        = reg_addr_w(NUM_REGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_issue_en,
  input  logic [AW-1:0]         i_issue_addr,
  input  logic [AW-1:0]         i_rd_addr_a,
  output logic [DATA_WIDTH-1:0] o_rd_data_a,
  input  logic [AW-1:0]         i_rd_addr_b,
  output logic [DATA_WIDTH-1:0] o_rd_data_b,
  output logic                  o_busy_a,
  output logic                  o_busy_b,
  output logic [NUM_REGS-1:0]   o_busy_vec
);
  logic [NUM_REGS-1:0][0:0]            w_we_dmx, w_set_dmx;
  logic [NUM_REGS-1:0]                 w_we, w_set;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]                 r_busy;
  logic                                w_wr_valid;
  logic [1:0][AW-1:0]                  w_ra;
  logic [1:0][DATA_WIDTH-1:0]          w_rd;
  logic [1:0]                          w_rbusy;

  reg_file_sb_demux #(.DATA_WIDTH(1), .NUM_OUTPUTS(NUM_REGS), .SEL_W(AW)) u_wr_dmx (
    .i_data(i_wr_en), .i_sel(i_wr_addr), .o_data(w_we_dmx)
  );

  reg_file_sb_demux #(.DATA_WIDTH(1), .NUM_OUTPUTS(NUM_REGS), .SEL_W(AW)) u_iss_dmx (
    .i_data(i_issue_en), .i_sel(i_issue_addr), .o_data(w_set_dmx)
  );

  // The hardwired-zero register never sees a write enable or a set, so it stays 0 and idle.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_mask
    localparam bit IS_ZERO = (ZERO_REG != 0) && (g == ZERO_REG_IDX);
    assign w_we[g]  = w_we_dmx[g][0]  && !IS_ZERO;
    assign w_set[g] = w_set_dmx[g][0] && !IS_ZERO;
  end

  assign w_wr_valid = |w_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_we[i]) r_regs[i] <= i_wr_data;
        // A new producer issued alongside a completing write keeps the bit set.
        r_busy[i] <= w_set[i] | (r_busy[i] & ~w_we[i]);
      end
    end
  end

  assign w_ra = {i_rd_addr_b, i_rd_addr_a};

  // Address match loop keeps out-of-range and zero-register reads at 0 without X.
  always_comb begin
    w_rd    = '0;
    w_rbusy = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (({1'b0, w_ra[p]} == (AW+1)'(i)) && !((ZERO_REG != 0) && (i == ZERO_REG_IDX))) begin
          w_rd[p]    = r_regs[i];
          w_rbusy[p] = r_busy[i];
        end
      end
      if (w_wr_valid && (i_wr_addr == w_ra[p])) begin
        w_rd[p]    = i_wr_data;
        w_rbusy[p] = 1'b0;
      end
    end
  end

  assign o_rd_data_a = w_rd[0];
  assign o_rd_data_b = w_rd[1];
  assign o_busy_a    = w_rbusy[0];
  assign o_busy_b    = w_rbusy[1];
  assign o_busy_vec  = r_busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a 32-entry instance and a 5-entry instance for out-of-range cases.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        wr_en, iss_en;
  logic [4:0]  wr_addr, iss_addr, ra, rb;
  logic [31:0] wr_data, rda, rdb, bvec;
  logic        ba, bb;

  logic        q_wr_en, q_iss_en;
  logic [2:0]  q_wr_addr, q_iss_addr, q_ra, q_rb;
  logic [31:0] q_wr_data, q_rda, q_rdb;
  logic [4:0]  q_bvec;
  logic        q_ba, q_bb;

  reg_file_sb #(.NUM_REGS(32), .DATA_WIDTH(32), .ZERO_REG(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_issue_en(iss_en), .i_issue_addr(iss_addr), .i_rd_addr_a(ra), .o_rd_data_a(rda),
    .i_rd_addr_b(rb), .o_rd_data_b(rdb), .o_busy_a(ba), .o_busy_b(bb), .o_busy_vec(bvec)
  );

  reg_file_sb #(.NUM_REGS(5), .DATA_WIDTH(32), .ZERO_REG(1)) u_dut5 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(q_wr_en), .i_wr_addr(q_wr_addr), .i_wr_data(q_wr_data),
    .i_issue_en(q_iss_en), .i_issue_addr(q_iss_addr), .i_rd_addr_a(q_ra), .o_rd_data_a(q_rda),
    .i_rd_addr_b(q_rb), .o_rd_data_b(q_rdb), .o_busy_a(q_ba), .o_busy_b(q_bb), .o_busy_vec(q_bvec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0; iss_en = 0; iss_addr = 0; ra = 0; rb = 0;
    q_wr_en = 0; q_wr_addr = 0; q_wr_data = 0; q_iss_en = 0; q_iss_addr = 0; q_ra = 0; q_rb = 0;
    tick(); tick();
    rst = 1'b0;

    // Load a few registers, then reset and confirm everything reads zero.
    wr(5'd4, 32'hCAFE0004);
    wr(5'd9, 32'h00000009);
    iss_en = 1; iss_addr = 5'd9; tick(); iss_en = 0;
    ra = 5'd4; #1 chk("preload_r4", rda, 32'hCAFE0004);
    chk("preload_busy9", bvec, 32'h0000_0200);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_busy_vec", bvec, 32'h0);
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i); #1;
      chk($sformatf("rst_rd_a_%0d", i), rda, 32'h0);
      chk($sformatf("rst_busy_a_%0d", i), {31'b0, ba}, 32'h0);
    end

    // Write then read, and same-cycle bypass.
    wr(5'd5, 32'hDEADBEEF);
    ra = 5'd5; #1 chk("rd_after_wr", rda, 32'hDEADBEEF);
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'h12345678; #1;
    chk("bypass_a", rda, 32'h12345678);
    tick(); wr_en = 0; #1;
    chk("rd_after_bypass", rda, 32'h12345678);

    // Zero register ignores writes, never bypasses and never goes busy.
    wr_en = 1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; ra = 5'd0; #1;
    chk("r0_no_bypass", rda, 32'h0);
    tick(); wr_en = 0; #1;
    chk("r0_read", rda, 32'h0);
    iss_en = 1; iss_addr = 5'd0; tick(); iss_en = 0;
    chk("r0_busy_vec", bvec, 32'h0);
    chk("r0_busy_a", {31'b0, ba}, 32'h0);

    // Scoreboard set, same-cycle clear override, registered clear.
    iss_en = 1; iss_addr = 5'd3; tick(); iss_en = 0;
    ra = 5'd3; #1;
    chk("sb_set_vec", bvec, 32'h0000_0008);
    chk("sb_set_busy_a", {31'b0, ba}, 32'h1);
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'h33; #1;
    chk("sb_wr_busy_a", {31'b0, ba}, 32'h0);
    chk("sb_wr_vec_raw", bvec, 32'h0000_0008);
    tick(); wr_en = 0; #1;
    chk("sb_clr_vec", bvec, 32'h0);
    chk("sb_clr_rd", rda, 32'h33);

    // Issue and write on the same register in one cycle: set wins.
    iss_en = 1; iss_addr = 5'd3; tick();
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'h34; tick();
    iss_en = 0; wr_en = 0; #1;
    chk("sb_conflict_vec", bvec, 32'h0000_0008);
    chk("sb_conflict_busy_a", {31'b0, ba}, 32'h1);
    chk("sb_conflict_data", rda, 32'h34);
    wr(5'd3, 32'h35);
    chk("sb_conflict_cleared", bvec, 32'h0);

    // Dual-port read, then reset while work is pending.
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    ra = 5'd1; rb = 5'd2; #1;
    chk("dual_a", rda, 32'h11);
    chk("dual_b", rdb, 32'h22);
    iss_en = 1; iss_addr = 5'd1; tick(); iss_en = 0;
    rb = 5'd1; #1 chk("pend_busy_b", {31'b0, bb}, 32'h1);
    rst = 1; wr_en = 1; wr_addr = 5'd1; wr_data = 32'h99; iss_en = 1; iss_addr = 5'd2;
    tick();
    rst = 0; wr_en = 0; iss_en = 0; #1;
    chk("rst_pend_vec", bvec, 32'h0);
    chk("rst_pend_r1", rda, 32'h0);
    chk("rst_pend_busy_b", {31'b0, bb}, 32'h0);
    rb = 5'd5; #1 chk("rst_pend_r5", rdb, 32'h0);

    // Out-of-range handling on the 5-entry instance.
    q_wr_en = 1; q_wr_addr = 3'd4; q_wr_data = 32'h44; tick();
    q_wr_addr = 3'd1; q_wr_data = 32'h11; tick();
    q_wr_addr = 3'd7; q_wr_data = 32'hAA; q_ra = 3'd7; q_rb = 3'd6; #1;
    chk("oor_no_bypass", q_rda, 32'h0);
    chk("oor_busy_a", {31'b0, q_ba}, 32'h0);
    tick(); q_wr_en = 0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] exp_v;
      exp_v = (i == 4) ? 32'h44 : (i == 1) ? 32'h11 : 32'h0;
      q_ra = 3'(i); #1;
      chk($sformatf("oor_keep_r%0d", i), q_rda, exp_v);
    end
    q_iss_en = 1; q_iss_addr = 3'd7; tick(); q_iss_en = 0;
    q_ra = 3'd7; q_rb = 3'd5; #1;
    chk("oor_busy_vec", {27'b0, q_bvec}, 32'h0);
    chk("oor_rd_a", q_rda, 32'h0);
    chk("oor_rd_b", q_rdb, 32'h0);
    chk("oor_busy_b", {31'b0, q_bb}, 32'h0);
    q_iss_en = 1; q_iss_addr = 3'd4; tick(); q_iss_en = 0;
    q_ra = 3'd4; #1;
    chk("n5_busy_vec4", {27'b0, q_bvec}, 32'h10);
    chk("n5_busy_a4", {31'b0, q_ba}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
